simple_adder_8bit: RTL and testbench
====================================

# simple_adder_8bit

8-bit ripple-carry adder with carry-in and carry-out. It provides a zero-latency combinational result plus a one-cycle registered copy with valid and status flags. It is a leaf arithmetic block used wherever a byte-wide add with carry chaining is needed. Downstream logic uses either the combinational or the registered path.

## Interface
Parameters:
- WIDTH, 8, operand/result width; the block is verified only at 8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry-in.
- in_valid  in  1  qualifies a/b/cin for the registered path.
- sum  out  WIDTH  combinational (a + b + cin) mod 2^WIDTH.
- cout  out  1  combinational carry out of the MSB.
- sum_q  out  WIDTH  registered sum.
- cout_q  out  1  registered carry.
- ovf_q  out  1  registered signed (two's-complement) overflow.
- zero_q  out  1  registered flag, high when the registered sum is 0.
- out_valid  out  1  high one cycle after an accepted in_valid.

## Operation
- {cout, sum} = a + b + cin, computed at WIDTH+1 bits with no truncation before the carry is taken.
- The sum and cout ports depend only on a, b and cin, never on clk or rst_n. They settle within the same time step as any input change.
- Implementation is a ripple chain of WIDTH full-adder cells:
  - cin feeds bit 0.
  - Each bit's carry feeds the next bit.
  - cout is the carry out of bit WIDTH-1.
- Signed overflow = carry into the MSB XOR carry out of the MSB.
- On each rising clk edge with rst_n=1:
  - If in_valid=1: sum_q, cout_q, ovf_q and zero_q load the current combinational results, and out_valid becomes 1.
  - If in_valid=0: sum_q, cout_q, ovf_q and zero_q hold their values, and out_valid becomes 0.
- Boundary results:
  - 255+0+1 wraps to sum 0 with cout=1.
  - 255+255+1 gives sum 255, cout=1.
  - 0+0+0 gives sum 0, cout=0, zero flag 1.

## Timing
- Combinational path has 0-cycle latency.
- Registered path has 1-cycle latency. in_valid sampled at edge N appears on sum_q/cout_q/ovf_q/zero_q/out_valid after edge N.
- Full throughput: a new operation can be accepted every cycle. There is no backpressure.
- Reset: when rst_n=0 at a rising edge, sum_q=0, cout_q=0, ovf_q=0, zero_q=0 and out_valid=0. The reset value of zero_q is 0, not 1.
- Reset wins over in_valid on the same edge.
- Reset asserted mid-stream discards the in-flight result. After reset, the first out_valid is one cycle after the first in_valid sampled with rst_n=1.
- No state machine.

## Structure
- Shared package: the WIDTH default constant, plus a typedef for the WIDTH-bit operand/result.
- One sub-module, full_adder_1bit, with ports a, b, cin, sum, cout. It is instantiated WIDTH times via generate.
- The top module contains the carry chain, the overflow/zero logic and the output register stage.

## Test plan
- Combinational checks, each made 10 ns after the inputs are applied:
  - a=0, b=0, cin=0 -> sum=0, cout=0.
  - a=255, b=0, cin=0 -> sum=255, cout=0.
  - a=255, b=0, cin=1 -> sum=0, cout=1.
  - a=128, b=127, cin=1 -> sum=0, cout=1.
  - a=127, b=127, cin=1 -> sum=255, cout=0.
  - a=128, b=128, cin=0 -> sum=0, cout=1.
- Registered path:
  - rst_n=0 for 2 cycles -> all registered outputs 0.
  - Then in_valid=1 with a=127, b=1, cin=0 -> next cycle sum_q=128, cout_q=0, ovf_q=1, zero_q=0, out_valid=1.
- Hold: after a valid op, drive in_valid=0 and change a/b -> registered outputs unchanged, out_valid=0, while the combinational sum tracks the new inputs.
- Back-to-back ops: in_valid high 3 cycles with (1,1,0), (200,100,0), (255,255,1) -> sum_q/cout_q sequence 2/0, 44/1, 255/1 on consecutive cycles.
- Reset mid-stream: in_valid=1 and rst_n=0 on the same edge -> out_valid=0, sum_q=0.
- Random: 1000 random a, b, cin -> {cout, sum} equals the 9-bit reference sum, and the registered path matches it one cycle later.

Source files
------------

// File: rtl/simple_adder_8bit_pkg.sv
// Shared constants and types for the byte-wide ripple-carry adder.
package simple_adder_8bit_pkg;

    localparam int unsigned ADDER_WIDTH = 8;

    typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage

// File: rtl/simple_adder_8bit_if.sv
// Operand/result bundle for simple_adder_8bit: the master drives operands, the slave returns results.
interface simple_adder_8bit_if;
    import simple_adder_8bit_pkg::*;

    word_t a;
    word_t b;
    logic  cin;
    logic  in_valid;
    word_t sum;
    logic  cout;
    word_t sum_q;
    logic  cout_q;
    logic  ovf_q;
    logic  zero_q;
    logic  out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  sum, cout, sum_q, cout_q, ovf_q, zero_q, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output sum, cout, sum_q, cout_q, ovf_q, zero_q, out_valid
    );

endinterface

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell; one link of the ripple chain.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half;

    assign half = a ^ b;
    assign sum  = half ^ cin;
    assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/simple_adder_8bit.sv
// Ripple-carry adder with a zero-latency result and a one-cycle registered copy plus flags.
module simple_adder_8bit
    import simple_adder_8bit_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    simple_adder_8bit_if.slave bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;
    logic             zero_c;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             valid_q;

    assign carry[0] = bus.cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chain
        full_adder_1bit u_fa (
            .a    (bus.a[g]),
            .b    (bus.b[g]),
            .cin  (carry[g]),
            .sum  (sum_c[g]),
            .cout (carry[g+1])
        );
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign ovf_c  = carry[WIDTH] ^ carry[WIDTH-1];
    assign zero_c = ~|sum_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum_c;
                cout_q <= carry[WIDTH];
                ovf_q  <= ovf_c;
                zero_q <= zero_c;
            end
        end
    end

    assign bus.sum       = sum_c;
    assign bus.cout      = carry[WIDTH];
    assign bus.sum_q     = sum_q;
    assign bus.cout_q    = cout_q;
    assign bus.ovf_q     = ovf_q;
    assign bus.zero_q    = zero_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_simple_adder_8bit.sv
// Directed and random checks of the combinational and registered adder paths.
module tb_simple_adder_8bit;
    import simple_adder_8bit_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    simple_adder_8bit_if bus ();

    simple_adder_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic vld);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = vld;
    endtask

    task automatic check_reg(input string name, input logic [7:0] es, input logic ec,
                             input logic eo, input logic ez, input logic ev);
        tests_run++;
        if ({bus.sum_q, bus.cout_q, bus.ovf_q, bus.zero_q, bus.out_valid} !== {es, ec, eo, ez, ev})
        begin
            tests_failed++;
            $display("FAIL %s: sum_q=%0d cout_q=%b ovf_q=%b zero_q=%b out_valid=%b, want %0d %b %b %b %b",
                     name, bus.sum_q, bus.cout_q, bus.ovf_q, bus.zero_q, bus.out_valid,
                     es, ec, eo, ez, ev);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reg("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_comb();
        logic [7:0] va [6] = '{8'd0, 8'd255, 8'd255, 8'd128, 8'd127, 8'd128};
        logic [7:0] vb [6] = '{8'd0, 8'd0,   8'd0,   8'd127, 8'd127, 8'd128};
        logic       vc [6] = '{1'b0, 1'b0,   1'b1,   1'b1,   1'b1,   1'b0};
        logic [8:0] ve [6] = '{9'd0, 9'd255, 9'd256, 9'd256, 9'd255, 9'd256};
        for (int i = 0; i < 6; i++) begin
            drive(va[i], vb[i], vc[i], 1'b0);
            #10;
            tests_run++;
            if ({bus.cout, bus.sum} !== ve[i]) begin
                tests_failed++;
                $display("FAIL comb[%0d]: cout=%b sum=%0d, want cout=%b sum=%0d",
                         i, bus.cout, bus.sum, ve[i][8], ve[i][7:0]);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'd127, 8'd1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_reg("registered", 8'd128, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_hold();
        @(negedge clk);
        drive(8'd10, 8'd20, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_reg("hold", 8'd128, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({bus.cout, bus.sum} !== 9'd30) begin
            tests_failed++;
            $display("FAIL hold_comb: sum=%0d cout=%b, want 30 0", bus.sum, bus.cout);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(8'd1, 8'd1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_reg("b2b_0", 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(8'd200, 8'd100, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_reg("b2b_1", 8'd44, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(8'd255, 8'd255, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_reg("b2b_2", 8'd255, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(8'd0, 8'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_reg("zero_flag", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        drive(8'd5, 8'd5, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reg("reset_mid", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reg("post_reset_idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'd3, 8'd4, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_reg("post_reset_first", 8'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] ref_sum;
        logic       ref_ovf;
        int         errs;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            drive(ra, rb, rc, 1'b1);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            ref_ovf = (ra[7] == rb[7]) && (ref_sum[7] != ra[7]);
            #1;
            tests_run++;
            if ({bus.cout, bus.sum} !== ref_sum) begin
                tests_failed++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_comb %0d+%0d+%0d: got %0d, want %0d",
                             ra, rb, rc, {bus.cout, bus.sum}, ref_sum);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if ({bus.cout_q, bus.sum_q, bus.ovf_q, bus.zero_q, bus.out_valid} !==
                {ref_sum, ref_ovf, ref_sum[7:0] == 8'd0, 1'b1}) begin
                tests_failed++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_reg %0d+%0d+%0d: got %0d ovf=%b z=%b v=%b, want %0d ovf=%b",
                             ra, rb, rc, {bus.cout_q, bus.sum_q}, bus.ovf_q, bus.zero_q,
                             bus.out_valid, ref_sum, ref_ovf);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_comb();
        test_registered();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
